// File: rtl/vce2_vrf_mem_resp_if.sv
// rtl/vce2_vrf_mem_resp_if.sv - req/gnt/rvalid element port between the vector AGU and the VRF memory responder
interface vce2_vrf_mem_resp_if #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
);
   logic                 req_i;
   logic                 we_i;
   logic [3:0]           be_i;
   logic [AddrWidth-1:0] addr_i;
   logic [DataWidth-1:0] wdata_i;
   logic                 gnt_o;
   logic                 rvalid_o;
   logic [DataWidth-1:0] rdata_o;
   logic                 err_o;
   logic                 init_done_o;

   modport master (
      output req_i, we_i, be_i, addr_i, wdata_i,
      input  gnt_o, rvalid_o, rdata_o, err_o, init_done_o
   );

   modport slave (
      input  req_i, we_i, be_i, addr_i, wdata_i,
      output gnt_o, rvalid_o, rdata_o, err_o, init_done_o
   );
endinterface

// File: rtl/vce2_vrf_mem_resp.sv
// rtl/vce2_vrf_mem_resp.sv - VRF element memory responder with post-reset clear sequence
// VCE2_MEM_LAT2_EN adds a second response register stage (2-cycle read/ack latency).
module vce2_vrf_mem_resp #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32,
   parameter int NumWords  = 256
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   vce2_vrf_mem_resp_if.slave    bus
);
   localparam int IdxW = $clog2(NumWords);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   state_e               r_state;
   state_e               w_state_nxt;
   logic [IdxW-1:0]      r_clr_cnt;
   logic [DataWidth-1:0] r_mem [NumWords];

   logic                 w_gnt;
   logic                 w_init_done;
   logic                 w_xfer;
   logic                 w_err;
   logic                 w_clr_last;
   logic [IdxW-1:0]      w_idx;

   logic                 r_rvalid;
   logic                 r_err;
   logic [DataWidth-1:0] r_rdata;

   assign w_idx      = bus.addr_i[IdxW+1:2];
   assign w_err      = (bus.addr_i[1:0] != 2'b00) || (bus.addr_i[AddrWidth-1:IdxW+2] != '0);
   assign w_clr_last = (r_clr_cnt == IdxW'(NumWords - 1));
   assign w_xfer     = bus.req_i & w_gnt;

   always_comb begin
      w_state_nxt = r_state;
      w_gnt       = 1'b0;
      w_init_done = 1'b0;
      case (r_state)
         ST_CLEAR: begin
            if (w_clr_last) begin
               w_state_nxt = ST_READY;
            end
         end
         ST_READY: begin
            w_gnt       = bus.req_i;
            w_init_done = 1'b1;
         end
         default: w_state_nxt = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= ST_CLEAR;
         r_clr_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + IdxW'(1);
         end
      end
   end

   // Storage has no reset; the CLEAR walk zeroes it one word per cycle instead.
   always_ff @(posedge clk_i) begin
      if (r_state == ST_CLEAR) begin
         r_mem[r_clr_cnt] <= '0;
      end else if (w_xfer && bus.we_i && !w_err) begin
         for (int b = 0; b < DataWidth / 8; b++) begin
            if (bus.be_i[b]) begin
               r_mem[w_idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= w_xfer;
         r_err    <= w_xfer & w_err;
         r_rdata  <= (w_xfer && !bus.we_i && !w_err) ? r_mem[w_idx] : '0;
      end
   end

`ifdef VCE2_MEM_LAT2_EN
   logic                 r_rvalid2;
   logic                 r_err2;
   logic [DataWidth-1:0] r_rdata2;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rvalid2 <= 1'b0;
         r_err2    <= 1'b0;
         r_rdata2  <= '0;
      end else begin
         r_rvalid2 <= r_rvalid;
         r_err2    <= r_err;
         r_rdata2  <= r_rdata;
      end
   end

   assign bus.rvalid_o = r_rvalid2;
   assign bus.err_o    = r_err2;
   assign bus.rdata_o  = r_rdata2;
`else
   assign bus.rvalid_o = r_rvalid;
   assign bus.err_o    = r_err;
   assign bus.rdata_o  = r_rdata;
`endif

   assign bus.gnt_o       = w_gnt;
   assign bus.init_done_o = w_init_done;
endmodule

// File: tb/tb_vce2_vrf_mem_resp.sv
// tb/tb_vce2_vrf_mem_resp.sv - self-checking bench for vce2_vrf_mem_resp against a word-array model
module tb_vce2_vrf_mem_resp;
`ifdef VCE2_MEM_LAT2_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int OBS_DEPTH = 8192;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   vce2_vrf_mem_resp_if bus_if ();

   vce2_vrf_mem_resp dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus_if)
   );

   int          tests_run    = 0;
   int          tests_failed = 0;
   int          edge_no      = 0;
   logic        obs_v [OBS_DEPTH];
   logic [31:0] obs_d [OBS_DEPTH];
   logic        obs_e [OBS_DEPTH];
   logic [31:0] model_mem [256];

   always @(posedge clk) edge_no <= edge_no + 1;

   // obs_*[n] holds the response visible in the cycle following rising edge n
   always @(negedge clk) begin
      if (edge_no < OBS_DEPTH) begin
         obs_v[edge_no] = bus_if.rvalid_o;
         obs_d[edge_no] = bus_if.rdata_o;
         obs_e[edge_no] = bus_if.err_o;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic clear_model();
      for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
   endtask

   task automatic idle(input int n);
      bus_if.req_i = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, output int g, output logic [31:0] xd, output logic xe);
      logic [7:0] idx;
      bus_if.req_i   = 1'b1;
      bus_if.we_i    = we;
      bus_if.be_i    = be;
      bus_if.addr_i  = addr;
      bus_if.wdata_i = wd;
      @(posedge clk);
      #1;
      g   = edge_no;
      idx = addr[9:2];
      xe  = (addr[1:0] != 2'b00) || (addr[31:10] != 22'h0);
      xd  = 32'h0;
      if (!xe) begin
         if (!we) xd = model_mem[idx];
         else
            for (int b = 0; b < 4; b++)
               if (be[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end
   endtask

   task automatic wait_clear(output int bad);
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         if (bus_if.gnt_o !== 1'b0 || bus_if.init_done_o !== 1'b0) bad++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      int bad;
      bus_if.req_i = 1'b1; bus_if.we_i = 1'b0; bus_if.be_i = 4'h0;
      bus_if.addr_i = 32'h0; bus_if.wdata_i = 32'h0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (bus_if.gnt_o !== 1'b0 || bus_if.rvalid_o !== 1'b0 || bus_if.init_done_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: gnt=%b rvalid=%b init_done=%b expected 0 0 0",
                  bus_if.gnt_o, bus_if.rvalid_o, bus_if.init_done_o);
      end
      tests_run++;
      if (bus_if.rdata_o !== 32'h0 || bus_if.err_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_data: rdata=%h err=%b expected 0 0", bus_if.rdata_o, bus_if.err_o);
      end
      rst_n = 1'b1;
      wait_clear(bad);
      tests_run++;
      if (bad !== 0) begin
         tests_failed++;
         $display("FAIL clear_no_gnt: %0d cycles with gnt/init_done high during clear, expected 0", bad);
      end
      tests_run++;
      if (bus_if.gnt_o !== 1'b1 || bus_if.init_done_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL clear_done_257: gnt=%b init_done=%b expected 1 1", bus_if.gnt_o, bus_if.init_done_o);
      end
      bus_if.req_i = 1'b0;
      clear_model();
   endtask

   task automatic test_write_read();
      int gw, gr;
      logic [31:0] xd;
      logic xe;
      idle(2);
      bus_if.req_i = 1'b1; bus_if.we_i = 1'b1;
      #1;
      tests_run++;
      if (bus_if.gnt_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL gnt_comb: gnt=%b expected 1", bus_if.gnt_o);
      end
      issue(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, gw, xd, xe);
      issue(1'b0, 4'h0, 32'h10, 32'h0, gr, xd, xe);
      idle(LAT + 2);
      tests_run++;
      if (obs_v[gw+LAT-2] !== 1'b0 || obs_v[gw+LAT-1] !== 1'b1 || obs_d[gw+LAT-1] !== 32'h0 || obs_e[gw+LAT-1] !== 1'b0) begin
         tests_failed++;
         $display("FAIL write_ack: v(early)=%b v=%b d=%h e=%b expected 0 1 0 0",
                  obs_v[gw+LAT-2], obs_v[gw+LAT-1], obs_d[gw+LAT-1], obs_e[gw+LAT-1]);
      end
      tests_run++;
      if (obs_v[gr+LAT-1] !== 1'b1 || obs_d[gr+LAT-1] !== 32'hDEADBEEF || obs_v[gr+LAT] !== 1'b0) begin
         tests_failed++;
         $display("FAIL read_deadbeef: v=%b d=%h v(next)=%b expected 1 deadbeef 0",
                  obs_v[gr+LAT-1], obs_d[gr+LAT-1], obs_v[gr+LAT]);
      end
   endtask

   task automatic test_byte_enable();
      int g;
      logic [31:0] xd;
      logic xe;
      issue(1'b1, 4'hF, 32'h20, 32'h11223344, g, xd, xe);
      issue(1'b1, 4'b0001, 32'h20, 32'h000000AA, g, xd, xe);
      issue(1'b0, 4'h0, 32'h20, 32'h0, g, xd, xe);
      idle(LAT + 2);
      tests_run++;
      if (obs_v[g+LAT-1] !== 1'b1 || obs_d[g+LAT-1] !== 32'h112233AA) begin
         tests_failed++;
         $display("FAIL byte_en: v=%b d=%h expected 1 112233aa", obs_v[g+LAT-1], obs_d[g+LAT-1]);
      end
      issue(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, g, xd, xe);
      issue(1'b0, 4'h0, 32'h20, 32'h0, g, xd, xe);
      idle(LAT + 2);
      tests_run++;
      if (obs_v[g+LAT-1] !== 1'b1 || obs_d[g+LAT-1] !== 32'h112233AA) begin
         tests_failed++;
         $display("FAIL be_zero_noop: v=%b d=%h expected 1 112233aa", obs_v[g+LAT-1], obs_d[g+LAT-1]);
      end
   endtask

   task automatic test_errors();
      int g0, g1, g2, g3;
      logic [31:0] xd;
      logic xe;
      issue(1'b1, 4'hF, 32'h0, 32'h12345678, g0, xd, xe);
      issue(1'b0, 4'h0, 32'h3FC, 32'h0, g0, xd, xe);
      issue(1'b0, 4'h0, 32'h400, 32'h0, g1, xd, xe);
      issue(1'b1, 4'hF, 32'h2, 32'hFFFFFFFF, g2, xd, xe);
      issue(1'b0, 4'h0, 32'h0, 32'h0, g3, xd, xe);
      idle(LAT + 2);
      tests_run++;
      if (obs_v[g0+LAT-1] !== 1'b1 || obs_d[g0+LAT-1] !== 32'h0 || obs_e[g0+LAT-1] !== 1'b0) begin
         tests_failed++;
         $display("FAIL read_top_word: v=%b d=%h e=%b expected 1 0 0", obs_v[g0+LAT-1], obs_d[g0+LAT-1], obs_e[g0+LAT-1]);
      end
      tests_run++;
      if (obs_v[g1+LAT-1] !== 1'b1 || obs_d[g1+LAT-1] !== 32'h0 || obs_e[g1+LAT-1] !== 1'b1) begin
         tests_failed++;
         $display("FAIL read_out_of_range: v=%b d=%h e=%b expected 1 0 1", obs_v[g1+LAT-1], obs_d[g1+LAT-1], obs_e[g1+LAT-1]);
      end
      tests_run++;
      if (obs_v[g2+LAT-1] !== 1'b1 || obs_e[g2+LAT-1] !== 1'b1) begin
         tests_failed++;
         $display("FAIL write_misaligned: v=%b e=%b expected 1 1", obs_v[g2+LAT-1], obs_e[g2+LAT-1]);
      end
      tests_run++;
      if (obs_d[g3+LAT-1] !== 32'h12345678 || obs_e[g3+LAT-1] !== 1'b0) begin
         tests_failed++;
         $display("FAIL word0_unchanged: d=%h e=%b expected 12345678 0", obs_d[g3+LAT-1], obs_e[g3+LAT-1]);
      end
   endtask

   task automatic test_back_to_back();
      int g0, g1, g2;
      logic [31:0] xd;
      logic xe;
      idle(1);
      issue(1'b1, 4'hF, 32'h8, 32'h5, g0, xd, xe);
      issue(1'b0, 4'h0, 32'h8, 32'h0, g1, xd, xe);
      issue(1'b0, 4'h0, 32'hC, 32'h0, g2, xd, xe);
      idle(LAT + 2);
      tests_run++;
      if (g1 != g0 + 1 || g2 != g0 + 2 || obs_v[g0+LAT-1] !== 1'b1 || obs_v[g0+LAT] !== 1'b1
          || obs_v[g0+LAT+1] !== 1'b1 || obs_v[g0+LAT+2] !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_valids: v=%b%b%b%b expected 1110", obs_v[g0+LAT-1], obs_v[g0+LAT],
                  obs_v[g0+LAT+1], obs_v[g0+LAT+2]);
      end
      tests_run++;
      if (obs_d[g0+LAT-1] !== 32'h0 || obs_d[g0+LAT] !== 32'h5 || obs_d[g0+LAT+1] !== 32'h0) begin
         tests_failed++;
         $display("FAIL b2b_data: d=%h %h %h expected 0 5 0", obs_d[g0+LAT-1], obs_d[g0+LAT], obs_d[g0+LAT+1]);
      end
   endtask

   task automatic test_random();
      localparam int N = 200;
      int          g  [N];
      logic [31:0] xd [N];
      logic        xe [N];
      int          bad_resp, bad_zero, nvalid;
      logic [31:0] addr;
      int          k;
      idle(1);
      for (int i = 0; i < N; i++) begin
         if ($urandom % 4 == 0) idle(1);
         addr = 32'($urandom_range(0, 31)) << 2;
         k = $urandom % 8;
         if (k == 0) addr = addr | 32'($urandom_range(1, 3));
         if (k == 1) addr = addr | (32'h1 << $urandom_range(10, 31));
         issue(1'($urandom % 2), 4'($urandom), addr, $urandom, g[i], xd[i], xe[i]);
      end
      idle(LAT + 2);
      bad_resp = 0;
      for (int i = 0; i < N; i++) begin
         if (obs_v[g[i]+LAT-1] !== 1'b1 || obs_d[g[i]+LAT-1] !== xd[i] || obs_e[g[i]+LAT-1] !== xe[i]) begin
            bad_resp++;
            if (bad_resp <= 4)
               $display("FAIL rand_resp[%0d]: v=%b d=%h e=%b expected 1 %h %b", i,
                        obs_v[g[i]+LAT-1], obs_d[g[i]+LAT-1], obs_e[g[i]+LAT-1], xd[i], xe[i]);
         end
      end
      tests_run++;
      if (bad_resp != 0) tests_failed++;
      bad_zero = 0;
      nvalid   = 0;
      for (int c = g[0] + LAT - 1; c <= g[N-1] + LAT + 1; c++) begin
         if (obs_v[c] === 1'b1) nvalid++;
         else if (obs_d[c] !== 32'h0 || obs_e[c] !== 1'b0) bad_zero++;
      end
      tests_run++;
      if (nvalid != N || bad_zero != 0) begin
         tests_failed++;
         $display("FAIL rand_window: rvalids=%0d idle_nonzero=%0d expected %0d 0", nvalid, bad_zero, N);
      end
   endtask

   task automatic test_reset_midflight();
      int g, gr, bad, lost;
      logic [31:0] xd;
      logic xe;
      issue(1'b1, 4'hF, 32'h10, 32'hCAFEF00D, g, xd, xe);
      idle(LAT + 2);
      issue(1'b0, 4'h0, 32'h10, 32'h0, g, xd, xe);
      rst_n = 1'b0;
      bus_if.req_i = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
      clear_model();
      lost = 0;
      for (int c = g; c <= g + 3; c++) if (obs_v[c] !== 1'b0) lost++;
      tests_run++;
      if (lost != 0) begin
         tests_failed++;
         $display("FAIL reset_drops_resp: %0d rvalid cycles after reset, expected 0", lost);
      end
      wait_clear(bad);
      tests_run++;
      if (bad != 0 || bus_if.init_done_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL reclear: bad=%0d init_done=%b expected 0 1", bad, bus_if.init_done_o);
      end
      issue(1'b0, 4'h0, 32'h10, 32'h0, gr, xd, xe);
      idle(LAT + 2);
      tests_run++;
      if (obs_v[gr+LAT-1] !== 1'b1 || obs_d[gr+LAT-1] !== 32'h0 || obs_d[gr+LAT-1] !== xd) begin
         tests_failed++;
         $display("FAIL reread_after_clear: v=%b d=%h expected 1 0", obs_v[gr+LAT-1], obs_d[gr+LAT-1]);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_enable();
      test_errors();
      test_back_to_back();
      test_random();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
